alu_issue_decoder: RTL
======================

# alu_issue_decoder

Decode/issue stage that sits directly upstream of the ALU and is the producer end of its operand/control interface. Accepts ARM data-processing and MUL instruction words together with register-file read data, and decodes the opcode into the team's 4-bit ALU control code. Builds operand A and operand B, including rotated immediates and immediate-shifted registers. Presents everything through a registered valid/ready output slot, and holds issue for multiply settle time.

## Interface
- MUL_CYCLES, 3: cycles from MUL acceptance to out_valid (legal range ≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  instruction and read data valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  ARM instruction word.
- rn_data / rm_data / rs_data  in  32 each  register values for instr[19:16] / instr[3:0] / instr[11:8], aligned with instr.
- out_valid  out  1  issue slot holds a decoded op.
- out_ready  in  1  ALU side consumes the slot.
- out_alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0101 MUL, 0110 XOR.
- out_operand_a, out_operand_b  out  32 each  ALU operands.
- out_rd  out  4  destination register.
- out_wr_en  out  1  result is written back.
- out_set_flags  out  1  flags are updated.
- illegal  out  1  one-cycle pulse: the accepted word was unsupported.

## Operation
- cond = 1111 → illegal. Otherwise cond is ignored.
- MUL is recognized by instr[27:22] = 000000 and instr[7:4] = 1001 (A bit must be 0, else illegal).
  - Fields: alu_control = 0101, a = rm_data, b = rs_data, rd = instr[19:16], wr_en = 1, set_flags = instr[20].
- Data-processing (instr[27:26] = 00), opcode instr[24:21] maps as follows:
  - AND → 0000
  - EOR → 0110
  - SUB → 0011
  - RSB → 0011 with a/b swapped
  - ADD → 0010
  - TST → 0000, wr_en = 0
  - TEQ → 0110, wr_en = 0
  - CMP → 0011, wr_en = 0
  - CMN → 0010, wr_en = 0
  - ORR → 0001
  - MOV → 0001 with a = 0
  - ADC, SBC, RSC, BIC, MVN → illegal.
- Data-processing fields: a = rn_data, rd = instr[15:12], set_flags = instr[20], forced to 1 for TST/TEQ/CMP/CMN.
- Operand B, immediate form (I = 1): zero-extended imm8 = instr[7:0], rotated right by 2 × instr[11:8].
- Operand B, register form (I = 0):
  - instr[4] must be 0; register-specified shifts are illegal.
  - Shift amount is sh = instr[11:7], type is instr[6:5].
  - LSL: rm << sh.
  - LSR: sh = 0 means shift by 32 → 0.
  - ASR: sh = 0 means 32 → all bits equal rm[31].
  - ROR: sh = 0 (RRX) → illegal.
- Any other encoding → illegal.
- An illegal word is consumed (handshake completes), nothing is issued, and illegal pulses for one cycle starting the cycle after acceptance.
- FSM:
  - IDLE: in_ready = !out_valid | out_ready.
    - Accept non-MUL → register outputs, out_valid = 1, stay IDLE.
    - Accept MUL with MUL_CYCLES = 1 → same as non-MUL.
    - Accept MUL with MUL_CYCLES > 1 → register outputs, load counter with MUL_CYCLES-1, go to MUL_WAIT.
  - MUL_WAIT: in_ready = 0, out_valid = 0. The counter decrements each cycle. At 1 → out_valid = 1, go to IDLE.
- Output fields change only on acceptance and stay stable while out_valid & !out_ready.

## Timing
- Reset: state IDLE, counter 0, all out_* 0, out_alu_control 0000, illegal 0, in_ready 1.
- Non-MUL latency: out_valid rises 1 cycle after the accept edge.
- MUL latency: out_valid rises MUL_CYCLES cycles after the accept edge. in_ready is low for MUL_CYCLES-1 cycles.
- Same-cycle consume and accept: out_valid stays 1 with the new fields. A slot consumed with no new accept → out_valid 0 the next cycle.
- Reset in MUL_WAIT aborts the op. The op is never issued.

## Test plan
- 0xE28210FF (ADD r1, r2, #0xFF), rn_data = 5 → next cycle: control 0010, a = 5, b = 0x000000FF, rd = 1, wr_en = 1, set_flags = 0.
- 0xE3A004FF (MOV r0, #0xFF000000) → control 0001, a = 0, b = 0xFF000000, rd = 0.
- 0xE0410242 (SUB r0, r1, r2, ASR #4), rn_data = 9, rm_data = 0x80000000 → control 0011, a = 9, b = 0xF8000000. Repeat with out_ready = 0 for 4 cycles → outputs frozen and in_ready = 0 until consumed.
- 0xE0050796 (MUL r5, r6, r7), rm_data = 3, rs_data = 7, MUL_CYCLES = 3 → in_ready low 2 cycles, out_valid rises on cycle 3 with control 0101, a = 3, b = 7, rd = 5. Assert rst during MUL_WAIT → out_valid never rises.
- 0xE0A10002 (ADC) → accepted, illegal = 1 for exactly one cycle, out_valid stays 0. 0xE1A00062 (RRX) → same.
- Back-to-back ADDs with out_ready = 1 → one issue per cycle, no bubbles, fields update every cycle.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: ARM DP/MUL decode and ALU issue slot.
// Ports: in_* request side, out_* registered issue slot, illegal pulse.
module alu_issue_decoder #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  input  logic [31:0] rs_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_control,
  output logic [31:0] out_operand_a,
  output logic [31:0] out_operand_b,
  output logic [3:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_set_flags,
  output logic        illegal
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {
    IDLE,
    MUL_WAIT
  } state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic        ov_q;
  logic        ill_q;
  logic [3:0]  ctl_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  rd_q;
  logic        we_q;
  logic        sf_q;

  logic        dec_ok;
  logic        dec_mul;
  logic [3:0]  dec_ctl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_rd;
  logic        dec_we;
  logic        dec_sf;
  logic [31:0] op2;
  logic        op2_ok;
  logic [31:0] imm32;
  logic [63:0] imm_rot;
  logic [63:0] rm_rot;
  logic [4:0]  sh;
  logic        accept;

  assign sh    = instr[11:7];
  assign imm32 = {24'b0, instr[7:0]};

  // Rotates done as a right shift of the value doubled up.
  assign imm_rot = {imm32, imm32} >> {instr[11:8], 1'b0};
  assign rm_rot  = {rm_data, rm_data} >> sh;

  always_comb begin
    op2    = '0;
    op2_ok = 1'b1;
    if (instr[25]) begin
      op2 = imm_rot[31:0];
    end else begin
      op2_ok = !instr[4];
      unique case (instr[6:5])
        2'b00: op2 = rm_data << sh;
        2'b01: op2 = (sh == 5'd0) ? '0 : rm_data >> sh;
        2'b10: op2 = (sh == 5'd0) ? {32{rm_data[31]}}
                                  : 32'($signed(rm_data) >>> sh);
        2'b11: begin
          op2 = rm_rot[31:0];
          if (sh == 5'd0) op2_ok = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dec_ok  = 1'b0;
    dec_mul = 1'b0;
    dec_ctl = 4'b0000;
    dec_a   = rn_data;
    dec_b   = op2;
    dec_rd  = instr[15:12];
    dec_we  = 1'b1;
    dec_sf  = instr[20];
    if (instr[31:28] == 4'hF) begin
      dec_ok = 1'b0;
    end else if (instr[27:22] == 6'b0 && instr[7:4] == 4'b1001) begin
      dec_ok  = !instr[21];
      dec_mul = 1'b1;
      dec_ctl = 4'b0101;
      dec_a   = rm_data;
      dec_b   = rs_data;
      dec_rd  = instr[19:16];
    end else if (instr[27:26] == 2'b00) begin
      dec_ok = op2_ok;
      unique case (instr[24:21])
        4'b0000: dec_ctl = 4'b0000;
        4'b0001: dec_ctl = 4'b0110;
        4'b0010: dec_ctl = 4'b0011;
        4'b0011: begin
          dec_ctl = 4'b0011;
          dec_a   = op2;
          dec_b   = rn_data;
        end
        4'b0100: dec_ctl = 4'b0010;
        4'b1000: dec_ctl = 4'b0000;
        4'b1001: dec_ctl = 4'b0110;
        4'b1010: dec_ctl = 4'b0011;
        4'b1011: dec_ctl = 4'b0010;
        4'b1100: dec_ctl = 4'b0001;
        4'b1101: begin
          dec_ctl = 4'b0001;
          dec_a   = '0;
        end
        default: dec_ok = 1'b0;
      endcase
      // Compare/test ops only update flags.
      if (instr[24:23] == 2'b10) begin
        dec_we = 1'b0;
        dec_sf = 1'b1;
      end
    end
  end

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      ill_q <= accept && !dec_ok;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ov_q <= 1'b0;
            if (dec_ok) begin
              ctl_q <= dec_ctl;
              a_q   <= dec_a;
              b_q   <= dec_b;
              rd_q  <= dec_rd;
              we_q  <= dec_we;
              sf_q  <= dec_sf;
              if (dec_mul && MUL_CYCLES > 1) begin
                cnt_q   <= CW'(MUL_CYCLES - 1);
                state_q <= MUL_WAIT;
              end else begin
                ov_q <= 1'b1;
              end
            end
          end else if (out_ready) begin
            ov_q <= 1'b0;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            ov_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign out_valid       = ov_q;
  assign out_alu_control = ctl_q;
  assign out_operand_a   = a_q;
  assign out_operand_b   = b_q;
  assign out_rd          = rd_q;
  assign out_wr_en       = we_q;
  assign out_set_flags   = sf_q;
  assign illegal         = ill_q;

endmodule
